nibble_parity_rx: RTL and testbench
===================================

Name: nibble_parity_rx

Overview:
Serial receiver for the 4-bit parity link. The peer drives a nibble with its XOR-reduction parity bit over one wire. This block deframes the serial stream, reconstructs the nibble, and recomputes its XOR parity. It reports the data with parity-error and framing-error flags, and sits at the receiving end of the gates-level nibble/parity path.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range is 2 and above. The mid-bit sample point is floor(CLKS_PER_BIT/2).

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
rx  input  1  serial line; idles high; synchronous to clk (no synchronizer inside)
data  output  4  received nibble; holds its value until the next accepted frame
valid  output  1  one-cycle pulse when a frame completes; data and the error flags are meaningful in that cycle
parity_err  output  1  high when the received parity bit does not equal the XOR of the 4 data bits; updated with valid
frame_err  output  1  high when the stop bit is sampled low; updated with valid
busy  output  1  high in every state except IDLE

Behaviour:
- Frame format, in order: start bit (0), d0, d1, d2, d3 (LSB first), parity p, stop bit (1). That is 7 bits of CLKS_PER_BIT cycles each. Even parity: p = d0^d1^d2^d3.
- Reset: state IDLE, bit counter and cycle counter 0, data 4'h0, valid 0, parity_err 0, frame_err 0, busy 0. Reset wins over all other activity, including mid-frame. The partial frame is discarded with no valid pulse.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on the edge where rx==0 is sampled (call it t0), go to START and clear the cycle counter.
- Sample points: bit k (start=0 … stop=6) is sampled at edge t0 + k*CLKS_PER_BIT + floor(CLKS_PER_BIT/2).
- START: at the sample point, rx==0 moves to DATA. rx==1 is a glitch: return to IDLE with no output change.
- DATA: shift each sampled bit into position bit_idx (0..3). After d3, go to PARITY.
- PARITY: store the sampled p, then go to STOP.
- STOP: at the sample point, register the following in the same edge:
  - valid=1
  - data = assembled nibble
  - parity_err = p ^ d0^d1^d2^d3
  - frame_err = ~rx
- After STOP: if rx==1, go to IDLE. If rx==0, go to BREAK.
- BREAK: wait until rx==1 is sampled, then go to IDLE. A low line is never treated as a new start while in BREAK.
- valid is high for exactly one cycle, the cycle after the stop-sample edge, and is 0 otherwise.
- Latency: valid is visible (6*CLKS_PER_BIT + floor(CLKS_PER_BIT/2) + 1) edges after t0.
- Back-to-back frames: after a good stop, a start bit beginning right after the stop bit period is received correctly. IDLE is re-entered before the stop bit ends.
- The error flags are sticky only until the next valid. They are not cleared by valid deasserting.
- data and the flags update only on valid. They do not update on a glitch or on reset-aborted frames, except that reset clears them.

Test Plan:
- Reset, CLKS_PER_BIT=4, send nibble 4'hA (bits 0,1,0,1; p=0; stop=1) -> one valid pulse 27 edges after t0; data=4'hA, parity_err=0, frame_err=0, busy returns to 0.
- Send 4'h7 with wrong parity p=0 (correct p=1) -> valid with data=4'h7, parity_err=1, frame_err=0.
- Send 4'h3 with correct p=0 and stop bit held low for 8 cycles -> valid with data=4'h3, frame_err=1. The block stays in BREAK (busy=1) until rx rises, and no spurious frame is received.
- Drive rx low for 1 cycle only, then high -> no valid, data and flags unchanged, busy back to 0 within CLKS_PER_BIT cycles.
- Assert rst for 1 cycle during d2 of a 4'hF frame, then send 4'h5 -> no valid for the aborted frame; all outputs 0 after reset; 4'h5 is then received with both error flags 0.
- Send 4'h1 then 4'hE back-to-back with no idle gap -> two valid pulses exactly 28 cycles apart; data 4'h1 then 4'hE; parity_err=0 both times.

Source files
------------

// File: rtl/nibble_parity_rx.sv
// Serial receiver for the 4-bit even-parity link: start, d0..d3 (LSB first), parity, stop.
// Reports the nibble with parity/framing error flags on a one-cycle valid pulse.
module nibble_parity_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       bit_idx;
  logic [3:0]       shreg;
  logic             par;
  logic             sample;

  function automatic logic parity_check(input logic [3:0] nib, input logic p);
    return p ^ (^nib);
  endfunction

  // The cycle counter restarts at t0, so the first (start-bit) sample lands
  // half a bit in; every later sample is a full bit after the previous one.
  always_comb begin
    sample    = (state == START) ? (cnt == CNT_HALF) : (cnt == CNT_LAST);
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rx) state_nxt = START;
      START:   if (sample) state_nxt = rx ? IDLE : DATA;
      DATA:    if (sample && bit_idx == 2'd3) state_nxt = PARITY;
      PARITY:  if (sample) state_nxt = STOP;
      STOP:    if (sample) state_nxt = rx ? IDLE : BREAK;
      BREAK:   if (rx) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 2'd0;
      data       <= 4'h0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= 1'b0;
      if (state == IDLE || state == BREAK || sample) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == START) bit_idx <= 2'd0;
      else if (state == DATA && sample) bit_idx <= bit_idx + 2'd1;
      if (state == STOP && sample) begin
        valid      <= 1'b1;
        data       <= shreg;
        parity_err <= parity_check(shreg, par);
        frame_err  <= ~rx;
      end
    end
  end

  // Assembly registers carry no reset: they are fully rewritten by every frame
  // before they are published.
  always_ff @(posedge clk) begin
    if (state == DATA && sample) shreg[bit_idx] <= rx;
    if (state == PARITY && sample) par <= rx;
  end

endmodule

// File: tb/tb_nibble_parity_rx.sv
// Directed self-checking bench for nibble_parity_rx at CLKS_PER_BIT=4.
module tb_nibble_parity_rx;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [3:0] data;
  logic       valid, parity_err, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0;

  int         v_cyc[$];
  logic [3:0] v_data[$];
  logic       v_pe[$];
  logic       v_fe[$];

  nibble_parity_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_data.push_back(data);
      v_pe.push_back(parity_err);
      v_fe.push_back(frame_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(C);
  endtask

  // Caller is positioned 1 time unit after a rising edge; t0 is the next edge.
  task automatic send_frame(input logic [3:0] nib, input logic p, input logic stop);
    t0 = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(nib[i]);
    send_bit(p);
    send_bit(stop);
    rx = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", data, 4'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_pe", parity_err, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick(1);

    // 4'hA, correct parity
    n = v_cyc.size();
    send_frame(4'hA, 1'b0, 1'b1);
    tick(3);
    check("a_count", v_cyc.size() - n, 1);
    check("a_latency", v_cyc[$] - t0 + 1, 27);
    check("a_data", v_data[$], 4'hA);
    check("a_pe", v_pe[$], 1'b0);
    check("a_fe", v_fe[$], 1'b0);
    check("a_busy", busy, 1'b0);

    // 4'h7 with wrong parity bit
    n = v_cyc.size();
    send_frame(4'h7, 1'b0, 1'b1);
    tick(3);
    check("b_count", v_cyc.size() - n, 1);
    check("b_data", v_data[$], 4'h7);
    check("b_pe", v_pe[$], 1'b1);
    check("b_fe", v_fe[$], 1'b0);

    // 4'h3 with stop held low for 8 cycles
    n = v_cyc.size();
    t0 = cyc + 1;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    tick(8);
    check("c_busy_break", busy, 1'b1);
    check("c_count", v_cyc.size() - n, 1);
    check("c_data", v_data[$], 4'h3);
    check("c_pe", v_pe[$], 1'b0);
    check("c_fe", v_fe[$], 1'b1);
    rx = 1'b1;
    tick(2);
    check("c_busy_idle", busy, 1'b0);
    tick(30);
    check("c_no_spurious", v_cyc.size() - n, 1);

    // single-cycle glitch
    n = v_cyc.size();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(C);
    check("g_busy", busy, 1'b0);
    tick(30);
    check("g_count", v_cyc.size() - n, 0);
    check("g_data", data, 4'h3);
    check("g_pe", parity_err, 1'b0);
    check("g_fe", frame_err, 1'b1);

    // reset during d2 of 4'hF, then 4'h5
    n = v_cyc.size();
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    rx = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("r_data", data, 4'h0);
    check("r_valid", valid, 1'b0);
    check("r_pe", parity_err, 1'b0);
    check("r_fe", frame_err, 1'b0);
    check("r_busy", busy, 1'b0);
    tick(40);
    check("r_count", v_cyc.size() - n, 0);
    send_frame(4'h5, 1'b0, 1'b1);
    tick(3);
    check("r5_count", v_cyc.size() - n, 1);
    check("r5_data", v_data[$], 4'h5);
    check("r5_pe", v_pe[$], 1'b0);
    check("r5_fe", v_fe[$], 1'b0);

    // back-to-back 4'h1 then 4'hE
    n = v_cyc.size();
    send_frame(4'h1, 1'b1, 1'b1);
    send_frame(4'hE, 1'b1, 1'b1);
    tick(3);
    check("bb_count", v_cyc.size() - n, 2);
    if (v_cyc.size() - n == 2) begin
      check("bb_gap", v_cyc[n+1] - v_cyc[n], 28);
      check("bb_data0", v_data[n], 4'h1);
      check("bb_data1", v_data[n+1], 4'hE);
      check("bb_pe0", v_pe[n], 1'b0);
      check("bb_pe1", v_pe[n+1], 1'b0);
      check("bb_fe1", v_fe[n+1], 1'b0);
    end
    check("bb_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
